// File: rtl/cc_topsideloader_if.sv
// Load/shift command and row-status bundle for cc_topsideloader.
// The master drives row commands; the slave (the loader) returns the row and its flags.
interface cc_topsideloader_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 4
);
  logic [DW-1:0] CC_TOPSIDELOADER_data_InBUS;
  logic          CC_TOPSIDELOADER_load_InHigh;
  logic          CC_TOPSIDELOADER_shiftleft_InHigh;
  logic          CC_TOPSIDELOADER_shiftright_InHigh;
  logic          CC_TOPSIDELOADER_shiftbit_In;
  logic          CC_TOPSIDELOADER_ready_OutHigh;
  logic [DW-1:0] CC_TOPSIDELOADER_data_OutBUS;
  logic          CC_TOPSIDELOADER_topside_OutHigh;
  logic          CC_TOPSIDELOADER_bottomside_OutHigh;
  logic          CC_TOPSIDELOADER_clear_OutHigh;
  logic [CW-1:0] CC_TOPSIDELOADER_rowcount_OutBUS;

  modport master (
    output CC_TOPSIDELOADER_data_InBUS, CC_TOPSIDELOADER_load_InHigh,
           CC_TOPSIDELOADER_shiftleft_InHigh, CC_TOPSIDELOADER_shiftright_InHigh,
           CC_TOPSIDELOADER_shiftbit_In,
    input  CC_TOPSIDELOADER_ready_OutHigh, CC_TOPSIDELOADER_data_OutBUS,
           CC_TOPSIDELOADER_topside_OutHigh, CC_TOPSIDELOADER_bottomside_OutHigh,
           CC_TOPSIDELOADER_clear_OutHigh, CC_TOPSIDELOADER_rowcount_OutBUS
  );

  modport slave (
    input  CC_TOPSIDELOADER_data_InBUS, CC_TOPSIDELOADER_load_InHigh,
           CC_TOPSIDELOADER_shiftleft_InHigh, CC_TOPSIDELOADER_shiftright_InHigh,
           CC_TOPSIDELOADER_shiftbit_In,
    output CC_TOPSIDELOADER_ready_OutHigh, CC_TOPSIDELOADER_data_OutBUS,
           CC_TOPSIDELOADER_topside_OutHigh, CC_TOPSIDELOADER_bottomside_OutHigh,
           CC_TOPSIDELOADER_clear_OutHigh, CC_TOPSIDELOADER_rowcount_OutBUS
  );
endinterface

// File: rtl/cc_topsideloader.sv
// Row register: load via ready handshake, serial shift, flash-and-clear of full rows
// with a saturating cleared-row counter. All outputs are flop outputs.
module cc_topsideloader #(
  parameter int unsigned TOPSIDELOADER_DATAWIDTH   = 8,
  parameter int unsigned TOPSIDELOADER_COUNTWIDTH  = 4,
  parameter int unsigned TOPSIDELOADER_CLEARCYCLES = 3
) (
  input logic                CC_TOPSIDELOADER_CLOCK_50,
  input logic                CC_TOPSIDELOADER_RESET_InHigh,
  cc_topsideloader_if.slave  bus
);
  localparam int unsigned W     = TOPSIDELOADER_DATAWIDTH;
  localparam int unsigned C     = TOPSIDELOADER_COUNTWIDTH;
  localparam int unsigned CNT_W = (TOPSIDELOADER_CLEARCYCLES > 1) ?
                                  $clog2(TOPSIDELOADER_CLEARCYCLES) : 1;
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(TOPSIDELOADER_CLEARCYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] FLASH  = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [W-1:0]     row, row_nxt;
  logic [CNT_W-1:0] flash_cnt, flash_cnt_nxt;
  logic [C-1:0]     rowcount, rowcount_nxt;
  logic             clear_nxt;
  logic             ready, topside, bottomside, clear;

  always_comb begin
    state_nxt     = state;
    row_nxt       = row;
    flash_cnt_nxt = flash_cnt;
    rowcount_nxt  = rowcount;
    clear_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.CC_TOPSIDELOADER_load_InHigh) begin
          row_nxt = bus.CC_TOPSIDELOADER_data_InBUS;
        end
      end
      ACTIVE: begin
        if (bus.CC_TOPSIDELOADER_shiftleft_InHigh && !bus.CC_TOPSIDELOADER_shiftright_InHigh) begin
          row_nxt = {row[W-2:0], bus.CC_TOPSIDELOADER_shiftbit_In};
        end else if (bus.CC_TOPSIDELOADER_shiftright_InHigh &&
                     !bus.CC_TOPSIDELOADER_shiftleft_InHigh) begin
          row_nxt = {bus.CC_TOPSIDELOADER_shiftbit_In, row[W-1:1]};
        end
      end
      FLASH: begin
        if (flash_cnt == FLASH_LAST) begin
          row_nxt       = '0;
          clear_nxt     = 1'b1;
          state_nxt     = IDLE;
          flash_cnt_nxt = '0;
          if (rowcount != '1) begin
            rowcount_nxt = rowcount + 1'b1;
          end
        end else begin
          flash_cnt_nxt = flash_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        row_nxt   = '0;
      end
    endcase

    // IDLE and ACTIVE share one classification of the updated row.
    if (state == IDLE || state == ACTIVE) begin
      flash_cnt_nxt = '0;
      if (&row_nxt) begin
        state_nxt = FLASH;
      end else if (row_nxt == '0) begin
        state_nxt = IDLE;
      end else begin
        state_nxt = ACTIVE;
      end
    end
  end

  always_ff @(posedge CC_TOPSIDELOADER_CLOCK_50) begin
    if (CC_TOPSIDELOADER_RESET_InHigh) begin
      state      <= IDLE;
      row        <= '0;
      flash_cnt  <= '0;
      rowcount   <= '0;
      clear      <= 1'b0;
      ready      <= 1'b1;
      topside    <= 1'b0;
      bottomside <= 1'b1;
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      flash_cnt  <= flash_cnt_nxt;
      rowcount   <= rowcount_nxt;
      clear      <= clear_nxt;
      ready      <= (state_nxt == IDLE);
      topside    <= &row_nxt;
      bottomside <= (row_nxt == '0);
    end
  end

  assign bus.CC_TOPSIDELOADER_ready_OutHigh      = ready;
  assign bus.CC_TOPSIDELOADER_data_OutBUS        = row;
  assign bus.CC_TOPSIDELOADER_topside_OutHigh    = topside;
  assign bus.CC_TOPSIDELOADER_bottomside_OutHigh = bottomside;
  assign bus.CC_TOPSIDELOADER_clear_OutHigh      = clear;
  assign bus.CC_TOPSIDELOADER_rowcount_OutBUS    = rowcount;
endmodule
